// File: rtl/jk_seq_pkg.sv
// Shared types and JK helper functions for the excitation sequencer.
// Functions work per bit (excite/next) or on a max-width vector (popcount).
package jk_seq_pkg;

    localparam int JK_MAXW = 16;
    localparam int POPW    = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXCITE = 2'd1,
        APPLY  = 2'd2
    } seq_state_t;

    // Don't-cares resolved to 0, so a bit already at target gets J=K=0.
    function automatic logic [1:0] jk_excite(input logic q, input logic t);
        return {~q & t, q & ~t};
    endfunction

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        return (j & ~q) | (~k & q);
    endfunction

    function automatic logic [POPW-1:0] popcount(input logic [JK_MAXW-1:0] v);
        logic [POPW-1:0] c;
        c = '0;
        for (int i = 0; i < JK_MAXW; i++) begin
            c = c + {{(POPW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of W JK flip-flops; q follows Q+ = J&~Q | ~K&Q every clock.
// One-cycle update, no backpressure; async active-high reset to 0.
module jk_bank
    import jk_seq_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_j,
    input  logic [W-1:0] i_k,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_q_nxt;

    always_comb begin
        w_q_nxt = '0;
        for (int i = 0; i < W; i++) begin
            w_q_nxt[i] = jk_next(r_q[i], i_j[i], i_k[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jk_excitation_sequencer.sv
// Queues target states and drives a JK bank to each one: j/k at +1, q=target and done at +2.
// One target per 3 cycles; in_ready drops when the FIFO is full, steps while busy are dropped.
module jk_excitation_sequencer
    import jk_seq_pkg::*;
#(
    parameter int W      = 2,
    parameter int DEPTH  = 4,
    parameter int TCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_state,
    input  logic              step,
    output logic              busy,
    output logic [W-1:0]      q,
    output logic [W-1:0]      j,
    output logic [W-1:0]      k,
    output logic              done,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [TCNT_W-1:0] toggle_cnt
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int SUMW = TCNT_W + POPW;

    logic [W-1:0]        r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [W-1:0]        r_t;
    logic [W-1:0]        r_j;
    logic [W-1:0]        r_k;
    logic [TCNT_W-1:0]   r_tcnt;

    logic                w_wr;
    logic                w_pop;
    logic [W-1:0]        w_head;
    logic [W-1:0]        w_q;
    logic [W-1:0]        w_j_nxt;
    logic [W-1:0]        w_k_nxt;
    logic [JK_MAXW-1:0]  w_diff_ext;
    logic [POPW-1:0]     w_flips;
    logic [SUMW-1:0]     w_sum;
    logic [TCNT_W-1:0]   w_tcnt_nxt;

    // Flags come from the registered count, so a pop never frees a slot for a same-cycle write.
    assign fifo_full  = (r_count == CW'(DEPTH));
    assign fifo_empty = (r_count == '0);
    assign in_ready   = ~fifo_full;
    assign w_wr       = in_valid & in_ready;
    assign w_head     = r_mem[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (step && !fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = EXCITE;
                end
            end
            EXCITE:  w_state_nxt = APPLY;
            APPLY:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_j_nxt = '0;
        w_k_nxt = '0;
        for (int i = 0; i < W; i++) begin
            {w_j_nxt[i], w_k_nxt[i]} = jk_excite(w_q[i], w_head[i]);
        end
    end

    always_comb begin
        w_diff_ext        = '0;
        w_diff_ext[W-1:0] = w_q ^ r_t;
    end

    assign w_flips    = popcount(w_diff_ext);
    assign w_sum      = SUMW'(r_tcnt) + SUMW'(w_flips);
    assign w_tcnt_nxt = (w_sum > SUMW'({TCNT_W{1'b1}})) ? {TCNT_W{1'b1}} : w_sum[TCNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= in_state;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_t <= w_head;
                        r_j <= w_j_nxt;
                        r_k <= w_k_nxt;
                    end
                end
                // The bank takes j/k on this same edge, so q still holds the pre-step value here.
                EXCITE: r_tcnt <= w_tcnt_nxt;
                APPLY: begin
                    r_j <= '0;
                    r_k <= '0;
                end
                default: ;
            endcase
        end
    end

    jk_bank #(
        .W (W)
    ) u_bank (
        .clk (clk),
        .rst (rst),
        .i_j (r_j),
        .i_k (r_k),
        .o_q (w_q)
    );

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == APPLY);
    assign q          = w_q;
    assign j          = r_j;
    assign k          = r_k;
    assign toggle_cnt = r_tcnt;

endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Scoreboard bench for jk_excitation_sequencer (W=2, DEPTH=4, TCNT_W=2 so saturation is reachable).
module tb_jk_excitation_sequencer;

    localparam int W      = 2;
    localparam int DEPTH  = 4;
    localparam int TCNT_W = 2;
    localparam int TMAX   = (1 << TCNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_state = '0;
    logic              step = 1'b0;
    logic              busy;
    logic [W-1:0]      q;
    logic [W-1:0]      j;
    logic [W-1:0]      k;
    logic              done;
    logic              fifo_empty;
    logic              fifo_full;
    logic [TCNT_W-1:0] toggle_cnt;

    jk_excitation_sequencer #(
        .W      (W),
        .DEPTH  (DEPTH),
        .TCNT_W (TCNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .step       (step),
        .busy       (busy),
        .q          (q),
        .j          (j),
        .k          (k),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] j;
        logic [W-1:0] k;
        int           cnt;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_fifo[$];
    logic [W-1:0] m_q = '0;
    int           m_cnt = 0;
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_done = 0;
    exp_t         mon_e;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int pc(input logic [W-1:0] v);
        int c = 0;
        for (int b = 0; b < W; b++) c += int'(v[b]);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_pop();
        exp_t         e;
        logic [W-1:0] t;
        int           c;
        t     = m_fifo.pop_front();
        e.j   = ~m_q & t;
        e.k   = m_q & ~t;
        e.q   = t;
        c     = m_cnt + pc(m_q ^ t);
        e.cnt = (c > TMAX) ? TMAX : c;
        sb.push_back(e);
        m_q   = t;
        m_cnt = e.cnt;
    endtask

    task automatic model_reset();
        m_fifo.delete();
        sb.delete();
        m_q   = '0;
        m_cnt = 0;
    endtask

    task automatic wr(input logic [W-1:0] v);
        chk("in_ready", in_ready, (m_fifo.size() < DEPTH));
        in_valid = 1'b1;
        in_state = v;
        if (m_fifo.size() < DEPTH) m_fifo.push_back(v);
        tick();
        in_valid = 1'b0;
    endtask

    // Caller guarantees the sequencer is idle, so a step is taken iff the model FIFO has data.
    task automatic stp();
        step = 1'b1;
        if (m_fifo.size() > 0) model_pop();
        tick();
        step = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        chk("idle", busy, 0);
    endtask

    task automatic chk_reset();
        chk("rst_q", q, 0);
        chk("rst_j", j, 0);
        chk("rst_k", k, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_tcnt", toggle_cnt, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (busy && !done) begin
                if (sb.size() == 0) begin
                    chk("excite_unexpected", busy, 0);
                end else begin
                    chk("j", j, sb[0].j);
                    chk("k", k, sb[0].k);
                end
            end
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("q", q, mon_e.q);
                    chk("tcnt", toggle_cnt, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;

        // Reset at power-up, then mid-run with an entry queued.
        #2;
        chk_reset();
        #10 rst = 1'b0;
        tick();
        wr(2'b10);
        #1 rst = 1'b1;
        #1;
        chk_reset();
        model_reset();
        #1 rst = 1'b0;
        tick();

        // Basic step with cycle-exact checks.
        wr(2'b11);
        wait_idle();
        stp();
        chk("n1_busy", busy, 1);
        chk("n1_j", j, 2'b11);
        chk("n1_k", k, 2'b00);
        tick();
        chk("n2_done", done, 1);
        chk("n2_q", q, 2'b11);
        chk("n2_tcnt", toggle_cnt, 2);
        tick();
        chk("n3_j", j, 0);
        chk("n3_k", k, 0);
        chk("n3_busy", busy, 0);
        chk("n3_done", done, 0);

        // Clearing bits, then a target equal to q.
        wr(2'b01);
        stp();
        wait_idle();
        wr(2'b01);
        d0 = n_done;
        stp();
        wait_idle();
        chk("same_done", n_done, d0 + 1);
        chk("same_tcnt", toggle_cnt, 3);

        // Fill, overflow write dropped, drain in order.
        wr(2'b01);
        wr(2'b10);
        wr(2'b11);
        wr(2'b00);
        chk("full", fifo_full, 1);
        chk("full_ready", in_ready, 0);
        wr(2'b01);
        chk("full_after_drop", fifo_full, 1);
        for (int n = 0; n < DEPTH; n++) begin
            stp();
            wait_idle();
        end
        chk("drained_empty", fifo_empty, 1);

        // Step on empty FIFO is ignored.
        d0 = n_done;
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("empty_step_busy", busy, 0);
        chk("empty_step_q", q, m_q);
        tick();
        chk("empty_step_done", n_done, d0);

        // Step held through EXCITE/APPLY yields a single transition.
        wr(2'b10);
        wr(2'b01);
        d0 = n_done;
        step = 1'b1;
        model_pop();
        tick();
        tick();
        tick();
        step = 1'b0;
        wait_idle();
        chk("held_one_done", n_done, d0 + 1);
        chk("held_q", q, 2'b10);
        chk("held_fifo_left", fifo_empty, 0);
        stp();
        wait_idle();
        chk("held_drained", fifo_empty, 1);

        // Write and step together on an empty FIFO: data queued, step ignored.
        in_valid = 1'b1;
        in_state = 2'b11;
        step     = 1'b1;
        m_fifo.push_back(2'b11);
        tick();
        in_valid = 1'b0;
        step     = 1'b0;
        chk("wrstep_busy", busy, 0);
        chk("wrstep_empty", fifo_empty, 0);
        stp();
        wait_idle();

        // Saturation from a clean counter.
        rst = 1'b1;
        #1;
        model_reset();
        rst = 1'b0;
        tick();
        wr(2'b11);
        stp();
        wait_idle();
        wr(2'b00);
        stp();
        wait_idle();
        wr(2'b11);
        stp();
        wait_idle();
        chk("sat_tcnt", toggle_cnt, TMAX);

        // Reset during EXCITE aborts the step and flushes the queue.
        wr(2'b01);
        wr(2'b10);
        stp();
        chk("abort_in_excite", busy, 1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("abort_q", q, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_empty", fifo_empty, 1);
        chk("abort_j", j, 0);
        d0 = n_done;
        #2 rst = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        chk("abort_no_done", n_done, d0);
        chk("abort_q_after", q, 0);
        chk("abort_empty_after", fifo_empty, 1);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jk_excitation_sequencer.md
Name: jk_excitation_sequencer

Overview:
- Synthesis-direction counterpart of our JK next-state analysis logic. Our analysis logic derives the next state from given J/K inputs; this block does the reverse.
- It accepts a stream of target states and derives the J/K excitation needed to reach each one.
- It applies that excitation to an internal bank of JK flip-flops, one target per step request.
- Used as a lab/bench stimulus engine for JK-based state machines. The J/K vectors are exported so downstream circuits can be driven or checked.

Parameters:
- W, 2, number of JK flip-flops (state width), 1..16
- DEPTH, 4, target-state FIFO depth, power of two, >=2
- TCNT_W, 8, width of saturating toggle counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  target-state write request
- in_ready  out  1  FIFO can accept; = !fifo_full (registered count)
- in_state  in  W  target state; captured when in_valid & in_ready
- step  in  1  request to advance to the next queued target
- busy  out  1  step in progress (EXCITE or APPLY)
- q  out  W  current JK bank state
- j  out  W  registered J excitation presented to bank
- k  out  W  registered K excitation presented to bank
- done  out  1  one-cycle pulse; q holds the new target
- fifo_empty  out  1  no queued targets
- fifo_full  out  1  DEPTH targets queued
- toggle_cnt  out  TCNT_W  total bits flipped since reset, saturating

Behaviour:
- Clocking: one clock domain (clk). Reset is asynchronous and active-high (rst). All state registers clear immediately on rst.
- Reset values:
  - q=0, j=0, k=0
  - busy=0, done=0
  - fifo_empty=1, fifo_full=0, in_ready=1
  - toggle_cnt=0
  - FSM=IDLE, FIFO pointers and count=0
- Excitation rule, per bit i, with don't-cares resolved to 0:
  - J[i] = ~q[i] & t[i]
  - K[i] = q[i] & ~t[i]
  - Invariant: applying J/K per Q+ = J&~Q | ~K&Q yields Q+ = t.
- FSM states: IDLE, EXCITE, APPLY.
  - IDLE: if step & !fifo_empty, pop the FIFO head into target reg t, register j/k from the current q and the head value, then go to EXCITE (cycle N is the accept edge).
  - IDLE: step while fifo_empty is ignored and no state changes.
  - EXCITE (cycle N+1): j/k are visible on the outputs; busy=1. The bank updates q from j/k on this edge; go to APPLY.
  - APPLY (cycle N+2): q==t; done=1 for exactly this cycle; busy=1. On exit, j and k clear to 0; go to IDLE.
  - step while busy is ignored, not queued. The next step can be accepted the cycle after APPLY.
- Latency: step accept -> j/k visible +1 cycle -> q=target and done +2 cycles. Throughput is one target per 3 cycles.
- Toggle counting: toggle_cnt += popcount(q ^ t), updated on the same edge q updates. It saturates at 2^TCNT_W-1 with no wrap.
- FIFO:
  - Order: first in, first out.
  - Write when full: in_ready is 0, so the write is not accepted and data is dropped.
  - Simultaneous write and pop are both allowed, including when full. in_ready uses the pre-pop count, so a write arriving while full is still refused that cycle.
  - Write into an empty FIFO in the same cycle as step: step sees empty and is ignored; the data is queued.
  - Pointers wrap modulo DEPTH.
- Target equal to q: j=k=0, done still pulses, toggle_cnt unchanged.
- rst asserted mid-step (EXCITE or APPLY):
  - The step aborts immediately and q returns to 0.
  - Queued entries are discarded.
  - No done pulse is generated.

Decomposition:
- Shared package jk_seq_pkg contains:
  - the FSM state enum (IDLE/EXCITE/APPLY)
  - the excitation function jk_excite(q, t) returning {J,K}
  - the JK next-state function jk_next(q, j, k)
  - the popcount function
- Sub-module jk_bank: W JK flip-flops with async active-high reset to 0; inputs j, k; output q.
- The FIFO is inline; it is small enough not to warrant a separate module.

Test Plan:
1. Reset: assert rst mid-run -> same cycle: q=00, j=k=00, busy=0, fifo_empty=1, in_ready=1, toggle_cnt=0.
2. Basic step:
   - Write 11, pulse step at cycle N.
   - Required: N+1 j=11, k=00, busy=1; N+2 q=11, done=1, toggle_cnt=2; N+3 j=k=00, busy=0.
3. Reset-clear case (from q=11):
   - Write 01, step -> j=00, k=10, then q=01, toggle_cnt=3.
   - Write 01 again, step -> j=k=00, done pulses, toggle_cnt stays 3.
4. FIFO full and order:
   - Write 01,10,11,00 -> fifo_full=1, in_ready=0.
   - Write 01 while full -> dropped.
   - Four steps -> q sequence 01,10,11,00; fifo_empty=1 afterwards.
5. Ignored steps:
   - step with FIFO empty -> busy stays 0, q unchanged.
   - step asserted during EXCITE -> ignored; only one done pulse.
6. Saturation and mid-step reset:
   - With TCNT_W=2, alternate targets 11/00 -> toggle_cnt saturates at 3.
   - rst during EXCITE -> no done, q=00, FIFO empty.
